ddd_projector_hs: RTL and testbench

//  Parametrised, handshaked successor to the fixed-latency perspective projector.

---
 rtl/ddd_projector_hs_if.sv | 29 ++
 rtl/ddd_projector_hs.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ddd_projector_hs.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddd_projector_hs_if.sv
// Triangle bus for the perspective projector: upstream triangle handshake,
// downstream screen-space triangle handshake, frame-done pulses and counters.
interface ddd_projector_hs_if #(
    parameter int unsigned COORD_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [9*COORD_W-1:0]      in_vtx;
    logic [15:0]               in_color;
    logic                      done_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [16+6*COORD_W-1:0]   out_tri;
    logic                      done_out;
    logic [15:0]               reject_count;
    logic [15:0]               cull_count;

    // Projector side
    modport slave (
        input  in_valid, in_vtx, in_color, done_in, out_ready,
        output in_ready, out_valid, out_tri, done_out, reject_count, cull_count
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_vtx, in_color, done_in, out_ready,
        input  in_ready, out_valid, out_tri, done_out, reject_count, cull_count
    );
endinterface

// File: rtl/ddd_projector_hs.sv
// Handshaked perspective projector: one triangle per transaction, near-plane
// reject, x/y projected by (|c|<<LOG_D)/z with two serial restoring dividers.
// Optional back-face culling: define DDD_PROJECTOR_CULL_BACKFACE_EN.
module ddd_projector_hs #(
    parameter int unsigned COORD_W  = 16,
    parameter int unsigned LOG_D    = 8,
    parameter int unsigned SCREEN_W = 1280,
    parameter int unsigned SCREEN_H = 720,
    parameter int          NEAR_Z   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ddd_projector_hs_if.slave     bus
);
    localparam int unsigned QW = COORD_W + LOG_D;
    localparam int unsigned CW = $clog2(QW + 1);
    localparam int unsigned TW = 16 + 6 * COORD_W;
    localparam logic [QW-1:0]             MAXQ   = QW'((64'd1 << (COORD_W - 1)) - 64'd1);
    localparam logic [COORD_W-1:0]        HALF_W = COORD_W'(SCREEN_W / 2);
    localparam logic [COORD_W-1:0]        HALF_H = COORD_W'(SCREEN_H / 2);
    localparam logic signed [COORD_W-1:0] NEAR_S = COORD_W'(NEAR_Z);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_CULL, S_OUT} state_e;

    state_e               state_q, state_d;
    logic [9*COORD_W-1:0] vtx_q, vtx_d;
    logic [15:0]          color_q, color_d;
    logic [1:0]           vsel_q, vsel_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [COORD_W-1:0]   divisor_q, divisor_d;
    logic [QW-1:0]        dqx_q, dqx_d, dqy_q, dqy_d;
    logic [COORD_W-1:0]   remx_q, remx_d, remy_q, remy_d;
    logic                 negx_q, negx_d, negy_q, negy_d;
    logic [COORD_W-1:0]   scr_q [6];
    logic [COORD_W-1:0]   scr_d [6];
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [TW-1:0]        out_tri_q, out_tri_d;
    logic                 done_out_q, done_out_d;
    logic                 done_flag_q, done_flag_d;
    logic [15:0]          reject_q, reject_d;
    logic [15:0]          cull_q, cull_d;

    logic [COORD_W:0]     remx_sh, remy_sh;
    logic                 gex, gey;
    logic [COORD_W-1:0]   remx_nx, remy_nx;
    logic [QW-1:0]        dqx_nx, dqy_nx;

    // Vertex field k (0..8) of {x1,y1,z1,x2,y2,z2,x3,y3,z3}
    function automatic logic [COORD_W-1:0] coord(input logic [9*COORD_W-1:0] v,
                                                 input int unsigned k);
        return v[(8 - k) * COORD_W +: COORD_W];
    endfunction

    // Divider dividend: |c| << LOG_D in QW bits
    function automatic logic [QW-1:0] dividend(input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = c[COORD_W-1] ? COORD_W'(-c) : c;
        return QW'(m) << LOG_D;
    endfunction

    // Clamp quotient, restore sign, recentre on the screen
    function automatic logic [COORD_W-1:0] finish(input logic [QW-1:0] q, input logic neg,
                                                  input logic [COORD_W-1:0] half);
        logic [COORD_W-1:0] m;
        logic [COORD_W-1:0] s;
        m = (q > MAXQ) ? COORD_W'(MAXQ) : q[COORD_W-1:0];
        s = neg ? COORD_W'(-m) : m;
        return COORD_W'(s + half);
    endfunction

    // One restoring-divide step for x and y (shared divisor z)
    always_comb begin
        remx_sh = {remx_q, dqx_q[QW-1]};
        remy_sh = {remy_q, dqy_q[QW-1]};
        gex     = remx_sh >= {1'b0, divisor_q};
        gey     = remy_sh >= {1'b0, divisor_q};
        remx_nx = gex ? COORD_W'(remx_sh - {1'b0, divisor_q}) : remx_sh[COORD_W-1:0];
        remy_nx = gey ? COORD_W'(remy_sh - {1'b0, divisor_q}) : remy_sh[COORD_W-1:0];
        dqx_nx  = {dqx_q[QW-2:0], gex};
        dqy_nx  = {dqy_q[QW-2:0], gey};
    end

`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
    localparam int unsigned AW = 2 * COORD_W + 3;
    logic signed [AW-1:0] dx2, dy2, dx3, dy3, area;
    // Signed doubled area of the screen triangle; > 0 means front-facing
    always_comb begin
        dx2  = AW'($signed(scr_q[2])) - AW'($signed(scr_q[0]));
        dy2  = AW'($signed(scr_q[3])) - AW'($signed(scr_q[1]));
        dx3  = AW'($signed(scr_q[4])) - AW'($signed(scr_q[0]));
        dy3  = AW'($signed(scr_q[5])) - AW'($signed(scr_q[1]));
        area = dx2 * dy3 - dy2 * dx3;
    end
`endif

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        vtx_d       = vtx_q;
        color_d     = color_q;
        vsel_d      = vsel_q;
        cnt_d       = cnt_q;
        divisor_d   = divisor_q;
        dqx_d       = dqx_q;
        dqy_d       = dqy_q;
        remx_d      = remx_q;
        remy_d      = remy_q;
        negx_d      = negx_q;
        negy_d      = negy_q;
        scr_d       = scr_q;
        out_valid_d = out_valid_q;
        out_tri_d   = out_tri_q;
        done_out_d  = 1'b0;
        done_flag_d = done_flag_q | bus.done_in;
        reject_d    = reject_q;
        cull_d      = cull_q;

        case (state_q)
            S_IDLE: begin
                if (done_flag_q) begin
                    done_out_d  = 1'b1;
                    done_flag_d = bus.done_in;
                end
                if (bus.in_valid && in_ready_q) begin
                    vtx_d   = bus.in_vtx;
                    color_d = bus.in_color;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ($signed(coord(vtx_q, 2)) < NEAR_S || $signed(coord(vtx_q, 5)) < NEAR_S ||
                    $signed(coord(vtx_q, 8)) < NEAR_S) begin
                    reject_d = (reject_q == 16'hFFFF) ? reject_q : reject_q + 16'd1;
                    state_d  = S_IDLE;
                end else begin
                    dqx_d     = dividend(coord(vtx_q, 0));
                    dqy_d     = dividend(coord(vtx_q, 1));
                    negx_d    = coord(vtx_q, 0) >> (COORD_W - 1) != '0;
                    negy_d    = coord(vtx_q, 1) >> (COORD_W - 1) != '0;
                    divisor_d = coord(vtx_q, 2);
                    remx_d    = '0;
                    remy_d    = '0;
                    vsel_d    = 2'd0;
                    cnt_d     = '0;
                    state_d   = S_DIV;
                end
            end
            S_DIV: begin
                if (vsel_q == 2'd3) begin
`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
                    state_d = S_CULL;
`else
                    out_valid_d = 1'b1;
                    out_tri_d   = {color_q, scr_q[0], scr_q[1], scr_q[2],
                                   scr_q[3], scr_q[4], scr_q[5]};
                    state_d     = S_OUT;
`endif
                end else if (cnt_q == CW'(QW - 1)) begin
                    // Last step: store this vertex, then start the next one
                    scr_d[2 * vsel_q]     = finish(dqx_nx, negx_q, HALF_W);
                    scr_d[2 * vsel_q + 1] = finish(dqy_nx, negy_q, HALF_H);
                    vsel_d = 2'(vsel_q + 2'd1);
                    cnt_d  = '0;
                    if (vsel_q != 2'd2) begin
                        dqx_d     = dividend(coord(vtx_q, 3 * 32'(vsel_q) + 3));
                        dqy_d     = dividend(coord(vtx_q, 3 * 32'(vsel_q) + 4));
                        negx_d    = coord(vtx_q, 3 * 32'(vsel_q) + 3) >> (COORD_W - 1) != '0;
                        negy_d    = coord(vtx_q, 3 * 32'(vsel_q) + 4) >> (COORD_W - 1) != '0;
                        divisor_d = coord(vtx_q, 3 * 32'(vsel_q) + 5);
                        remx_d    = '0;
                        remy_d    = '0;
                    end
                end else begin
                    dqx_d  = dqx_nx;
                    dqy_d  = dqy_nx;
                    remx_d = remx_nx;
                    remy_d = remy_nx;
                    cnt_d  = CW'(cnt_q + 1'b1);
                end
            end
`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
            S_CULL: begin
                if (area <= 0) begin
                    cull_d  = (cull_q == 16'hFFFF) ? cull_q : cull_q + 16'd1;
                    state_d = S_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    out_tri_d   = {color_q, scr_q[0], scr_q[1], scr_q[2],
                                   scr_q[3], scr_q[4], scr_q[5]};
                    state_d     = S_OUT;
                end
            end
`endif
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vtx_q       <= '0;
            color_q     <= '0;
            vsel_q      <= '0;
            cnt_q       <= '0;
            divisor_q   <= '0;
            dqx_q       <= '0;
            dqy_q       <= '0;
            remx_q      <= '0;
            remy_q      <= '0;
            negx_q      <= 1'b0;
            negy_q      <= 1'b0;
            for (int i = 0; i < 6; i++) scr_q[i] <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_tri_q   <= '0;
            done_out_q  <= 1'b0;
            done_flag_q <= 1'b0;
            reject_q    <= '0;
            cull_q      <= '0;
        end else begin
            state_q     <= state_d;
            vtx_q       <= vtx_d;
            color_q     <= color_d;
            vsel_q      <= vsel_d;
            cnt_q       <= cnt_d;
            divisor_q   <= divisor_d;
            dqx_q       <= dqx_d;
            dqy_q       <= dqy_d;
            remx_q      <= remx_d;
            remy_q      <= remy_d;
            negx_q      <= negx_d;
            negy_q      <= negy_d;
            scr_q       <= scr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_tri_q   <= out_tri_d;
            done_out_q  <= done_out_d;
            done_flag_q <= done_flag_d;
            reject_q    <= reject_d;
            cull_q      <= cull_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_tri      = out_tri_q;
    assign bus.done_out     = done_out_q;
    assign bus.reject_count = reject_q;
    assign bus.cull_count   = cull_q;
endmodule

// File: tb/tb_ddd_projector_hs.sv
// Randomised bench for ddd_projector_hs against an arithmetic projection model.
module tb_ddd_projector_hs;
`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
    localparam int LAT = 75;
`else
    localparam int LAT = 74;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_rej = 0;
    int   exp_cull = 0;

    ddd_projector_hs_if #(.COORD_W(16)) bus();
    ddd_projector_hs dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Screen coordinate of one axis: (|c|*256)/z clamped, signed, recentred
    function automatic logic [15:0] proj(input int c, input int z, input int half);
        longint m, q, s;
        m = (c < 0) ? -longint'(c) : longint'(c);
        q = (m * 256) / z;
        if (q > 32767) q = 32767;
        s = (c < 0) ? -q : q;
        return 16'(s + half);
    endfunction

    function automatic logic [143:0] pack(input int v[9]);
        logic [143:0] r;
        for (int k = 0; k < 9; k++) r[(8-k)*16 +: 16] = 16'(v[k]);
        return r;
    endfunction

    // outcome: 0 = output, 1 = near-plane reject, 2 = back-face cull
    task automatic run_tri(input int v[9], input logic [15:0] col, input int stall,
                           input bit pulse_done);
        logic [111:0] exp_tri;
        logic [15:0]  s [6];
        int  outcome, n;
        bit  seen, rdy_bad, stable;
        longint a;
        outcome = 0;
        for (int i = 0; i < 3; i++) begin
            if (v[3*i+2] < 1) outcome = 1;
            if (outcome == 0) begin
                s[2*i]   = proj(v[3*i],   v[3*i+2], 640);
                s[2*i+1] = proj(v[3*i+1], v[3*i+2], 360);
            end
        end
        if (outcome == 0) begin
            exp_tri = {col, s[0], s[1], s[2], s[3], s[4], s[5]};
            a = (longint'($signed(s[2])) - $signed(s[0])) * (longint'($signed(s[5])) - $signed(s[1]))
              - (longint'($signed(s[3])) - $signed(s[1])) * (longint'($signed(s[4])) - $signed(s[0]));
`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
            if (a <= 0) outcome = 2;
`endif
        end else begin
            exp_tri = '0;
            a = 0;
        end

        n = 0;
        while (!bus.in_ready && n < 200) begin tick(); n++; end
        if (!bus.in_ready) begin
            check("in_ready_wait", 0, 1);
            return;
        end
        bus.in_vtx   = pack(v);
        bus.in_color = col;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_vtx   = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        bus.in_color = 16'($urandom());

        if (outcome != 0) begin
            n = 0;
            seen = 1'b0;
            while (!bus.in_ready && n < 200) begin
                tick(); n++;
                if (bus.out_valid) seen = 1'b1;
            end
            check("no_output", 128'(seen), 0);
            if (outcome == 1) begin
                exp_rej++;
                check("reject_turnaround", 128'(n <= 2), 1);
            end else begin
                exp_cull++;
            end
            check("reject_count", 128'(bus.reject_count), 128'(exp_rej));
            check("cull_count", 128'(bus.cull_count), 128'(exp_cull));
            return;
        end

        n = 0;
        rdy_bad = 1'b0;
        while (!bus.out_valid && n < 200) begin
            bus.done_in = (pulse_done && n == 30);
            tick(); n++;
            if (bus.in_ready) rdy_bad = 1'b1;
        end
        bus.done_in = 1'b0;
        check("latency", 128'(n), 128'(LAT));
        check("in_ready_busy", 128'(rdy_bad), 0);
        check("out_tri", 128'(bus.out_tri), 128'(exp_tri));

        if (stall > 0) begin
            stable = 1'b1;
            for (int i = 0; i < stall; i++) begin
                tick();
                if (bus.out_tri !== exp_tri || !bus.out_valid || bus.in_ready) stable = 1'b0;
            end
            check("stall_hold", 128'(stable), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", 128'(bus.out_valid), 0);
        check("in_ready_after", 128'(bus.in_ready), 1);
        if (pulse_done) begin
            check("done_early", 128'(bus.done_out), 0);
            tick();
            check("done_pulse", 128'(bus.done_out), 1);
            tick();
            check("done_clear", 128'(bus.done_out), 0);
        end else begin
            check("done_idle", 128'(bus.done_out), 0);
        end
        check("cull_count", 128'(bus.cull_count), 128'(exp_cull));
    endtask

    initial begin
        int v[9];
        int r;
        bus.in_valid  = 1'b0;
        bus.in_vtx    = '0;
        bus.in_color  = '0;
        bus.done_in   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 128'(bus.in_ready), 0);
        check("rst_out_valid", 128'(bus.out_valid), 0);
        check("rst_out_tri", 128'(bus.out_tri), 0);
        check("rst_done_out", 128'(bus.done_out), 0);
        check("rst_reject", 128'(bus.reject_count), 0);
        check("rst_cull", 128'(bus.cull_count), 0);
        rst_n = 1'b1;
        tick();
        check("in_ready_release", 128'(bus.in_ready), 1);

        v = '{0, 0, 256, 256, 0, 256, 0, 256, 256};
        run_tri(v, 16'hF800, 0, 1'b0);
        v = '{-512, -256, 512, 512, 256, 512, 0, 0, 512};
        run_tri(v, 16'h07E0, 0, 1'b0);
        v = '{10, 10, 0, 20, 20, 100, 30, 30, 100};
        run_tri(v, 16'h001F, 0, 1'b0);
        v = '{10, 10, 100, 20, 20, 100, 30, 30, -5};
        run_tri(v, 16'h001F, 0, 1'b0);
        v = '{30000, -32768, 1, -100, 32767, 3, 0, 0, 32767};
        run_tri(v, 16'h1234, 20, 1'b0);
        v = '{100, 50, 300, 400, 60, 300, 120, 500, 300};
        run_tri(v, 16'hABCD, 0, 1'b1);
`ifdef DDD_PROJECTOR_CULL_BACKFACE_EN
        v = '{0, 0, 256, 0, 256, 256, 256, 0, 256};
        run_tri(v, 16'hF800, 0, 1'b0);
`endif

        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 9; k++) begin
                if (k % 3 == 2) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) v[k] = 0;
                    else if (r == 1) v[k] = -int'($urandom_range(1, 32768));
                    else if (r == 2) v[k] = 1;
                    else v[k] = int'($urandom_range(1, 2000));
                end else if ($urandom_range(0, 1) == 0) begin
                    v[k] = int'($urandom_range(0, 2000)) - 1000;
                end else begin
                    v[k] = int'($urandom_range(0, 65535)) - 32768;
                end
            end
            run_tri(v, 16'($urandom()), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while a triangle is being divided
        v = '{100, 200, 300, 400, 500, 600, 700, 800, 900};
        while (!bus.in_ready) tick();
        bus.in_vtx   = pack(v);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 128'(bus.in_ready), 0);
        check("midrst_out_valid", 128'(bus.out_valid), 0);
        check("midrst_out_tri", 128'(bus.out_tri), 0);
        check("midrst_reject", 128'(bus.reject_count), 0);
        check("midrst_cull", 128'(bus.cull_count), 0);
        exp_rej  = 0;
        exp_cull = 0;
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_ready_back", 128'(bus.in_ready), 1);
        v = '{-256, 256, 256, 0, -256, 256, 256, 0, 256};
        run_tri(v, 16'h5555, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
